cc_req_arbiter: RTL
===================

Name: cc_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one code_converter datapath among NREQ requesters. It accepts a 4-bit operand and a one-hot 4-bit conversion select from each requester. It drives the converter's packed operand and active-low enable, then captures the 8-bit result and returns it to the winning requester, tagged with that requester's ID. Invalid selects and converter timeouts are reported as errors. The block sits between client blocks (ALU sequencer, test engines) and the single converter instance.

Parameters:
NREQ, 4, number of requesters; legal range 2..8
ID_W, 2, width of requester ID; 2**ID_W >= NREQ required
TIMEOUT, 8, maximum WAIT cycles for cc_done_in before an error response; legal range >= 2

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_n_in  input  1  asynchronous active-low reset
req_in  input  NREQ  per-requester request level; held high until ack
op_in  input  4*NREQ  requester i select at [4i+3:4i]: 0001 gray, 0010 xs-3, 0100 xs-5, 1000 bcd
data_in  input  4*NREQ  requester i operand at [4i+3:4i]
ack_out  output  NREQ  one-cycle pulse on the winner's bit when its request is accepted
rsp_valid_out  output  1  one-cycle response strobe
rsp_id_out  output  ID_W  requester index of the response
rsp_data_out  output  8  conversion result; 0 on error
rsp_err_out  output  1  1 = invalid select or timeout; qualified by rsp_valid_out
cc_a_out  output  8  to converter: {operand, select}
cc_en_n_out  output  1  to converter: active-low enable
cc_y_in  input  8  from converter: result
cc_done_in  input  1  from converter: done

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE, rr_ptr=0, timer=0, ack_out=0, rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, rsp_err_out=0, cc_a_out=0, cc_en_n_out=1.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE, with no request: hold all outputs; ack_out=0, rsp_valid_out=0.
- IDLE arbitration: winner = first i with req_in[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
- IDLE, on a grant at that edge:
  - ack_out[i]=1 for one cycle; latch op and data; rsp_id_out=i; rr_ptr=(i+1) mod NREQ.
  - Valid one-hot select: cc_a_out={data_in[i], op_in[i]}, cc_en_n_out=0, timer=0, go to WAIT.
  - Invalid select (not exactly one of 0001/0010/0100/1000): converter stays disabled; rsp_valid_out=1, rsp_err_out=1, rsp_data_out=0; go to RESP.
- WAIT, cc_done_in=1: rsp_data_out=cc_y_in, rsp_err_out=0, rsp_valid_out=1, cc_en_n_out=1, cc_a_out=0; go to RESP.
- WAIT, cc_done_in=0: timer+1. If timer==TIMEOUT-1: rsp_valid_out=1, rsp_err_out=1, rsp_data_out=0, cc_en_n_out=1, cc_a_out=0; go to RESP.
- cc_done_in is ignored outside WAIT. The converter's done is sticky, so it is sampled only after the enable has been asserted.
- RESP: rsp_valid_out=0; go to IDLE. No arbitration happens in RESP.
- Latency, normal case: ack at edge E0, rsp_valid_out high after E0+1, next grant possible at E0+3. Throughput is one conversion per 3 cycles.
- Latency, invalid select: rsp_valid_out rises at E0 together with ack; next grant possible at E0+2.
- Requester protocol:
  - A requester must hold req_in, op_in and data_in stable until it sees ack_out.
  - It may drop req_in after ack; re-asserting req_in in the ack cycle is a new request.
  - Dropping req_in before ack withdraws the request; this is legal.
- Simultaneous requests: exactly one ack per grant. A continuously requesting set of N requesters is served in strict rotation; no requester waits more than NREQ-1 grants.
- rr_ptr advances only on a grant. It never advances on an idle cycle or in RESP.
- rsp_data_out, rsp_id_out and rsp_err_out hold their values until the next response is loaded or reset.
- Reset mid-operation: the in-flight transaction is dropped with no response, and cc_en_n_out returns to 1 immediately. Requesters still holding req_in are re-arbitrated from rr_ptr=0.

Test Plan:
- Single request: req_in=0001, op=0010, data=0101 -> ack_out=0001 at E0; cc_a_out=0x52 and cc_en_n_out=0 for one cycle; rsp_valid at E0+1 with id=0, data=0x08, err=0.
- All four requesters held high with valid ops -> acks in order 0,1,2,3,0 at edges E0, E0+3, E0+6, E0+9, E0+12; each response id matches its ack.
- Invalid select: req_in=0100, op=0011 -> ack_out=0100, rsp_valid with id=2, err=1, data=0x00 at the same edge; cc_en_n_out stays 1.
- Timeout: converter model ties cc_done_in=0 -> rsp_err_out=1, data=0 exactly TIMEOUT cycles after ack (8 with defaults); FSM returns to IDLE.
- Fairness after a skip: rr_ptr=2, only req 0 and req 3 high -> req 3 granted first, then req 0.
- Async reset while in WAIT -> all outputs at reset values without a clock edge; no rsp_valid for the dropped transaction; a held request is re-served starting from requester 0.

Source files
------------

// File: rtl/cc_req_arbiter.sv
// rtl/cc_req_arbiter.sv - round-robin arbiter sharing one code_converter among NREQ requesters
module cc_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [NREQ-1:0]   req_in,
    input  logic [4*NREQ-1:0] op_in,
    input  logic [4*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   ack_out,
    output logic              rsp_valid_out,
    output logic [ID_W-1:0]   rsp_id_out,
    output logic [7:0]        rsp_data_out,
    output logic              rsp_err_out,
    output logic [7:0]        cc_a_out,
    output logic              cc_en_n_out,
    input  logic [7:0]        cc_y_in,
    input  logic              cc_done_in
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [TW-1:0]     timer;

    logic [NREQ-1:0]   req_rot;
    logic [ID_W:0]     idx_sum;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_next;
    logic [3:0]        grant_op;
    logic [3:0]        grant_data;
    logic              sel_ok;

    // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
    always_comb begin
        req_rot   = NREQ'({req_in, req_in} >> rr_ptr);
        grant_vld = 1'b0;
        idx_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_vld = 1'b1;
                idx_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
            end
        end
        if (idx_sum >= (ID_W+1)'(NREQ)) begin
            grant_idx = ID_W'(idx_sum - (ID_W+1)'(NREQ));
        end else begin
            grant_idx = ID_W'(idx_sum);
        end
        rr_next = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    always_comb begin
        grant_op   = 4'd0;
        grant_data = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_op   = op_in[4*i +: 4];
                grant_data = data_in[4*i +: 4];
            end
        end
        sel_ok = (grant_op != 4'd0) && ((grant_op & (grant_op - 4'd1)) == 4'd0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            timer         <= '0;
            ack_out       <= '0;
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_data_out  <= 8'd0;
            rsp_err_out   <= 1'b0;
            cc_a_out      <= 8'd0;
            cc_en_n_out   <= 1'b1;
        end else begin
            ack_out       <= '0;
            rsp_valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        ack_out    <= NREQ'(1) << grant_idx;
                        rsp_id_out <= grant_idx;
                        rr_ptr     <= rr_next;
                        if (sel_ok) begin
                            cc_a_out    <= {grant_data, grant_op};
                            cc_en_n_out <= 1'b0;
                            timer       <= '0;
                            state       <= S_WAIT;
                        end else begin
                            rsp_valid_out <= 1'b1;
                            rsp_err_out   <= 1'b1;
                            rsp_data_out  <= 8'd0;
                            state         <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cc_done_in) begin
                        rsp_valid_out <= 1'b1;
                        rsp_err_out   <= 1'b0;
                        rsp_data_out  <= cc_y_in;
                        cc_en_n_out   <= 1'b1;
                        cc_a_out      <= 8'd0;
                        state         <= S_RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_valid_out <= 1'b1;
                        rsp_err_out   <= 1'b1;
                        rsp_data_out  <= 8'd0;
                        cc_en_n_out   <= 1'b1;
                        cc_a_out      <= 8'd0;
                        state         <= S_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
